// File: rtl/fifo_arbiter_if.sv
// FIFO-side bus of the switch scheduler: input-FIFO read port and shared output-FIFO write port.
interface fifo_arbiter_if #(
  parameter int DATA_W = 6
);
  logic [3:0]          in_empty;
  logic [4*DATA_W-1:0] in_data;
  logic [3:0]          in_valid;
  logic [3:0]          out_pause;
  logic [3:0]          out_full;
  logic [3:0]          in_rd;
  logic [3:0]          out_wr;
  logic [DATA_W-1:0]   out_data;

  modport master (
    input  in_empty, in_data, in_valid, out_pause, out_full,
    output in_rd, out_wr, out_data
  );

  modport slave (
    output in_empty, in_data, in_valid, out_pause, out_full,
    input  in_rd, out_wr, out_data
  );
endinterface

// File: rtl/fifo_arbiter.sv
// Round-robin scheduler from four input class FIFOs to four output FIFOs, routing by the
// destination bits of each word; also distributes almost-empty/almost-full thresholds.
module fifo_arbiter #(
  parameter int DATA_W = 6,
  parameter int THR_W  = 5
) (
  input  logic             clk,
  input  logic             RESET_L,
  input  logic             init,
  input  logic [THR_W-1:0] umbral_empty_in,
  input  logic [THR_W-1:0] umbral_full_in,
  output logic [THR_W-1:0] umbral_empty_out,
  output logic [THR_W-1:0] umbral_full_out,
  fifo_arbiter_if.master   bus,
  output logic [2:0]       state,
  output logic             idle,
  output logic             err
);
  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } st_t;

  st_t               st;
  logic [1:0]        last, gnt, idx, rd_idx, cap_dst;
  logic              gnt_vld, cap;
  logic [1:0]        vld_pipe;  // [0]: read issued last cycle, [1]: write stage occupied
  logic [3:0]        rd;
  logic [DATA_W-1:0] cap_word;

  // Walk from last+4 (== last, lowest priority) down to last+1 so the nearest index wins.
  always_comb begin
    gnt     = last;
    gnt_vld = 1'b0;
    idx     = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (!bus.in_empty[idx]) begin
        gnt     = idx;
        gnt_vld = 1'b1;
      end
    end
  end

  assign rd = (RESET_L && st == S_ACTIVE && gnt_vld && bus.out_pause == 4'b0000)
              ? (4'b0001 << gnt) : 4'b0000;
  assign bus.in_rd = rd;

  assign cap_word = bus.in_data[rd_idx*DATA_W +: DATA_W];
  assign cap_dst  = cap_word[DATA_W-1 -: 2];
  assign cap      = vld_pipe[0] && bus.in_valid[rd_idx] && st == S_ACTIVE;
  assign state    = st;

  always_ff @(posedge clk) begin
    if (!RESET_L) begin
      st               <= S_RESET;
      last             <= 2'd3;
      rd_idx           <= 2'd0;
      vld_pipe         <= 2'b00;
      umbral_empty_out <= '0;
      umbral_full_out  <= '0;
      bus.out_wr       <= 4'b0000;
      bus.out_data     <= '0;
      idle             <= 1'b0;
      err              <= 1'b0;
    end else begin
      vld_pipe   <= {1'b0, |rd};
      rd_idx     <= gnt;
      bus.out_wr <= 4'b0000;
      idle       <= 1'b0;
      case (st)
        S_RESET: st <= S_INIT;
        S_INIT: begin
          umbral_empty_out <= umbral_empty_in;
          umbral_full_out  <= umbral_full_in;
          if (!init) begin
            st   <= S_IDLE;
            idle <= 1'b1;
          end
        end
        S_IDLE: begin
          if (init)                        st   <= S_INIT;
          else if (bus.in_empty != 4'hF)   st   <= S_ACTIVE;
          else                             idle <= 1'b1;
        end
        S_ACTIVE: begin
          if (|rd) last <= gnt;
          if (bus.in_empty == 4'hF && vld_pipe == 2'b00) begin
            st   <= S_IDLE;
            idle <= 1'b1;
          end
          if (cap) begin
            // A full destination drops the word and locks the scheduler until reset.
            if (bus.out_full[cap_dst]) begin
              err <= 1'b1;
              st  <= S_ERROR;
            end else begin
              bus.out_wr   <= 4'b0001 << cap_dst;
              bus.out_data <= cap_word;
              vld_pipe[1]  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter: input FIFOs return data one cycle after each read strobe.
module tb_fifo_arbiter;
  logic       clk = 1'b0;
  logic       RESET_L, init;
  logic [4:0] ue, uf, ueo, ufo;
  logic [2:0] state;
  logic       idle, err;
  logic [5:0] fw [4];
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  fifo_arbiter_if #(.DATA_W(6)) bus ();

  fifo_arbiter #(.DATA_W(6), .THR_W(5)) dut (
    .clk              (clk),
    .RESET_L          (RESET_L),
    .init             (init),
    .umbral_empty_in  (ue),
    .umbral_full_in   (uf),
    .umbral_empty_out (ueo),
    .umbral_full_out  (ufo),
    .bus              (bus),
    .state            (state),
    .idle             (idle),
    .err              (err)
  );

  assign bus.in_data = {fw[3], fw[2], fw[1], fw[0]};
  always @(posedge clk) bus.in_valid <= bus.in_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic look;
    @(negedge clk);
  endtask

  initial begin
    RESET_L = 1'b0; init = 1'b0; ue = 5'd0; uf = 5'd0;
    bus.in_empty = 4'hF; bus.out_pause = 4'h0; bus.out_full = 4'h0;
    fw[0] = 6'b00_0001; fw[1] = 6'b01_0010; fw[2] = 6'b10_0011; fw[3] = 6'b11_0100;

    // reset state
    repeat (3) @(posedge clk);
    look;
    chk("rst_state", state, 0);      chk("rst_idle", idle, 0);
    chk("rst_err", err, 0);          chk("rst_ueo", ueo, 0);
    chk("rst_ufo", ufo, 0);          chk("rst_in_rd", bus.in_rd, 0);
    chk("rst_out_wr", bus.out_wr, 0); chk("rst_out_data", bus.out_data, 0);

    // threshold load
    tick; RESET_L = 1'b1; init = 1'b1; ue = 5'd2; uf = 5'd6;
    tick; look; chk("init_state", state, 1);
    tick; init = 1'b0; look;
    chk("init_ueo", ueo, 2); chk("init_ufo", ufo, 6); chk("init_hold", state, 1);
    tick; look; chk("idle_state", state, 2); chk("idle_flag", idle, 1);

    // all four non-empty, round robin from last=3
    tick; bus.in_empty = 4'b0000;
    tick; look; chk("rr_active", state, 3); chk("rr0", bus.in_rd, 4'b0001);
    tick; look; chk("rr1", bus.in_rd, 4'b0010);
    tick; look; chk("rr2", bus.in_rd, 4'b0100);
    chk("rr_wr0", bus.out_wr, 4'b0001); chk("rr_dat0", bus.out_data, 6'h01);
    tick; look; chk("rr3", bus.in_rd, 4'b1000);
    chk("rr_wr1", bus.out_wr, 4'b0010); chk("rr_dat1", bus.out_data, 6'h12);
    tick; look; chk("rr4", bus.in_rd, 4'b0001);
    chk("rr_wr2", bus.out_wr, 4'b0100); chk("rr_dat2", bus.out_data, 6'h23);

    // pause for three cycles; in-flight words still land
    tick; bus.out_pause = 4'b0100; look;
    chk("pz_rd0", bus.in_rd, 0); chk("pz_wr3", bus.out_wr, 4'b1000); chk("pz_dat3", bus.out_data, 6'h34);
    tick; look;
    chk("pz_rd1", bus.in_rd, 0); chk("pz_wr0", bus.out_wr, 4'b0001); chk("pz_dat0", bus.out_data, 6'h01);
    tick; look; chk("pz_rd2", bus.in_rd, 0); chk("pz_wr_none", bus.out_wr, 0);
    tick; bus.out_pause = 4'b0000; look; chk("pz_resume", bus.in_rd, 4'b0010);
    tick; bus.in_empty = 4'hF; look; chk("pz_gap", bus.out_wr, 0);
    tick; look; chk("pz_wr1", bus.out_wr, 4'b0010); chk("pz_dat1", bus.out_data, 6'h12);
    tick; tick; look; chk("drain_idle", state, 2);

    // single non-empty FIFO1, word dest 2
    tick; bus.in_empty = 4'b1101; fw[1] = 6'b10_0101;
    tick; look; chk("one_active", state, 3); chk("one_rd", bus.in_rd, 4'b0010);
    tick; bus.in_empty = 4'hF; look; chk("one_rd_off", bus.in_rd, 0); chk("one_n1", bus.out_wr, 0);
    tick; look; chk("one_wr", bus.out_wr, 4'b0100); chk("one_dat", bus.out_data, 6'h25);
    tick; tick; look; chk("one_idle", state, 2);

    // routing into a full output FIFO
    tick; bus.in_empty = 4'b0111; bus.out_full = 4'b1000;
    tick; look; chk("full_rd", bus.in_rd, 4'b1000);
    tick; bus.in_empty = 4'hF; look;
    tick; look; chk("full_wr", bus.out_wr, 0); chk("full_err", err, 1); chk("full_state", state, 4);
    tick; bus.in_empty = 4'b0000; look; chk("err_rd", bus.in_rd, 0); chk("err_hold", state, 4);
    tick; tick; look; chk("err_state2", state, 4); chk("err_wr2", bus.out_wr, 0); chk("err_sticky", err, 1);

    // reset clears the error, then reset right after a read discards the word
    tick; RESET_L = 1'b0; bus.out_full = 4'h0; bus.in_empty = 4'hF; look;
    tick; look;
    chk("rst2_state", state, 0); chk("rst2_err", err, 0);
    chk("rst2_ueo", ueo, 0);     chk("rst2_dat", bus.out_data, 0);
    tick; RESET_L = 1'b1; bus.in_empty = 4'b1110;
    tick; look; chk("rst2_init", state, 1);
    tick; look; chk("rst2_idle", state, 2);
    tick; look; chk("rst2_last3", bus.in_rd, 4'b0001);
    tick; RESET_L = 1'b0; bus.in_empty = 4'hF;
    tick; RESET_L = 1'b1; look; chk("kill_wr", bus.out_wr, 0); chk("kill_state", state, 0);
    tick; look; chk("kill_wr2", bus.out_wr, 0); chk("kill_init", state, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
